// File: rtl/cpu_boot_loader_if.sv
// cpu_boot_loader_if
// Groups the byte-stream handshake and the instruction-memory write port of
// the boot loader into one bundle.
//   in_valid / in_data / in_ready : byte stream (source -> loader)
//   imem_we / imem_addr / imem_wdata : word writes (loader -> instruction memory)
// Modports:
//   master : stream source / memory side (testbench or upstream logic)
//   slave  : the loader itself
interface cpu_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
// Boot stage in front of the CPU. Parses a byte stream:
//   4 bytes start PC (MSB first), 2 bytes word count (MSB first),
//   then 4*count payload bytes assembled into big-endian 32-bit words that are
//   written to instruction memory at consecutive word addresses from 0.
// The CPU is held (cpu_run=0) until the last word is committed.
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of every previously accepted byte; mismatch -> error.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-low
//   bus      : cpu_boot_loader_if.slave (byte stream + imem write port)
//   init_pc  : start PC (valid once the header PC is received)
//   cpu_run  : 1 = CPU may run (loading complete)
//   load_err : 1 = load rejected (count too large or bad checksum)
module cpu_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    cpu_boot_loader_if.slave bus,
    output logic [31:0]      init_pc,
    output logic             cpu_run,
    output logic             load_err
);
    // Largest legal word count: the full memory.
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_PC = 3'd0, S_CNT = 3'd1, S_LOAD = 3'd2, S_CHK = 3'd3, S_RUN = 3'd4, S_ERR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_PC = 3'd0, S_CNT = 3'd1, S_LOAD = 3'd2, S_RUN = 3'd4, S_ERR = 3'd5
    } state_t;
`endif

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg;
    logic [15:0]       cnt_reg;
    logic [1:0]        bcnt_reg;
    logic [31:0]       w_reg;
    logic [ADDR_W:0]   widx_reg;
    logic              in_ready_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_reg;
`endif

    logic        accept;
    logic [15:0] cnt_full;
    logic        last_word;
    logic        payload_done;

    assign accept       = bus.in_valid && in_ready_reg;
    // Count value as it will be once the current (second) count byte lands.
    assign cnt_full     = {cnt_reg[7:0], bus.in_data};
    // The word currently being assembled is the final one.
    assign last_word    = (17'(widx_reg) + 17'd1) == {1'b0, cnt_reg};
    // Every payload word has been received (widx counts received words).
    assign payload_done = 17'(widx_reg) == {1'b0, cnt_reg};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_PC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_PC: begin
                if (accept && bcnt_reg == 2'd3) begin
                    state_next = S_CNT;
                end
            end
            S_CNT: begin
                if (accept && bcnt_reg == 2'd1) begin
                    if (cnt_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_RUN;
`endif
                    end else if ({1'b0, cnt_full} > CAP) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
                // Checksum byte may follow immediately, even during the
                // final write cycle, so move on as soon as the last byte lands.
                if (accept && bcnt_reg == 2'd3 && last_word) begin
                    state_next = S_CHK;
                end
`else
                // Leave only after the final write strobe has been presented,
                // so the CPU never fetches before the last word commits.
                if (imem_we_reg && payload_done) begin
                    state_next = S_RUN;
                end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_next = (bus.in_data == xor_reg) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN:   state_next = S_RUN;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    // Datapath: header capture, word assembly, write strobe generation
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_reg         <= '0;
            cnt_reg        <= '0;
            bcnt_reg       <= '0;
            w_reg          <= '0;
            widx_reg       <= '0;
            in_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg        <= '0;
`endif
        end else begin
            imem_we_reg  <= 1'b0;
            in_ready_reg <= (state_next != S_RUN) && (state_next != S_ERR);
            if (accept) begin
                unique case (state_reg)
                    S_PC: begin
                        pc_reg   <= {pc_reg[23:0], bus.in_data};
                        bcnt_reg <= bcnt_reg + 2'd1;
                    end
                    S_CNT: begin
                        cnt_reg  <= cnt_full;
                        bcnt_reg <= (bcnt_reg == 2'd1) ? 2'd0 : bcnt_reg + 2'd1;
                    end
                    S_LOAD: begin
                        // Bytes arriving after the last word are dropped.
                        if (!payload_done) begin
                            w_reg    <= {w_reg[23:0], bus.in_data};
                            bcnt_reg <= bcnt_reg + 2'd1;
                            if (bcnt_reg == 2'd3) begin
                                imem_we_reg    <= 1'b1;
                                imem_wdata_reg <= {w_reg[23:0], bus.in_data};
                                imem_addr_reg  <= widx_reg[ADDR_W-1:0];
                                widx_reg       <= widx_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
`ifdef LOADER_CHECKSUM_EN
                if (state_reg == S_PC || state_reg == S_CNT ||
                    (state_reg == S_LOAD && !payload_done)) begin
                    xor_reg <= xor_reg ^ bus.in_data;
                end
`endif
            end
        end
    end

    // Output logic
    always_comb begin
        bus.in_ready   = in_ready_reg;
        bus.imem_we    = imem_we_reg;
        bus.imem_addr  = imem_addr_reg;
        bus.imem_wdata = imem_wdata_reg;
        init_pc        = pc_reg;
        cpu_run        = (state_reg == S_RUN);
        load_err       = (state_reg == S_ERR);
    end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader
// Directed testbench for cpu_boot_loader (ADDR_W=8). One task per scenario,
// each with its own inline comparisons; one summary line at the end.
module tb_cpu_boot_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] init_pc;
    logic        cpu_run;
    logic        load_err;

    cpu_boot_loader_if #(.ADDR_W(8)) bus();

    cpu_boot_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .init_pc  (init_pc),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;
    int run_cyc = -1;
    int wr_addr[$];
    logic [31:0] wr_data[$];
    int wr_cyc[$];
    logic [7:0] stream[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(int'(bus.imem_addr));
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
            $display("[TB] write addr=%0d data=%08h cyc=%0d", bus.imem_addr, bus.imem_wdata, cyc);
        end
        if (cpu_run === 1'b1 && run_cyc < 0) run_cyc = cyc;
    end

    task automatic put32(input logic [31:0] v);
        stream.push_back(v[31:24]);
        stream.push_back(v[23:16]);
        stream.push_back(v[15:8]);
        stream.push_back(v[7:0]);
    endtask

    task automatic put16(input logic [15:0] v);
        stream.push_back(v[15:8]);
        stream.push_back(v[7:0]);
    endtask

    function automatic logic [7:0] stream_xor();
        logic [7:0] x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        return x;
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        run_cyc = -1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one byte; returns one cycle later with last_acc = accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_byte: in_ready=%b required 1 within 50 cycles", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic send_stream(input int gap, input bit chk_ready);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    if (chk_ready && i < stream.size() - 1) begin
                        tests++;
                        if (bus.in_ready !== 1'b1) begin
                            fails++;
                            $display("FAIL stall_ready: byte %0d gap %0d in_ready=%b required 1", i, g, bus.in_ready);
                        end
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (cpu_run !== 1'b1 && load_err !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (cpu_run !== 1'b1 && load_err !== 1'b1) begin
            fails++;
            $display("FAIL wait_done: no cpu_run/load_err within %0d cycles", bound);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests += 7;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL rst_imem_we: got %b want 0", bus.imem_we); end
        if (bus.imem_addr !== 8'h00) begin fails++; $display("FAIL rst_imem_addr: got %h want 00", bus.imem_addr); end
        if (bus.imem_wdata !== 32'h0) begin fails++; $display("FAIL rst_imem_wdata: got %h want 0", bus.imem_wdata); end
        if (init_pc !== 32'h0) begin fails++; $display("FAIL rst_init_pc: got %h want 0", init_pc); end
        if (cpu_run !== 1'b0) begin fails++; $display("FAIL rst_cpu_run: got %b want 0", cpu_run); end
        if (load_err !== 1'b0) begin fails++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    endtask

    // Basic load (gap 0) and stalled stream (gap 3) share this scenario.
    task automatic test_load(input int gap, input string name);
        int exp_run;
        do_reset();
        stream.delete();
        put32(32'h0000_0040);
        put16(16'd2);
        put32(32'h2001_0005);
        put32(32'h0021_1020);
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(stream_xor());
`endif
        send_stream(gap, gap > 0);
        wait_done(40);
        tests += 6;
        if (wr_addr.size() != 2) begin
            fails++;
            $display("FAIL %s_wr_count: got %0d want 2", name, wr_addr.size());
        end else begin
            if (wr_addr[0] != 0 || wr_data[0] !== 32'h2001_0005) begin
                fails++;
                $display("FAIL %s_wr0: got addr %0d data %h want 0 20010005", name, wr_addr[0], wr_data[0]);
            end
            if (wr_addr[1] != 1 || wr_data[1] !== 32'h0021_1020) begin
                fails++;
                $display("FAIL %s_wr1: got addr %0d data %h want 1 00211020", name, wr_addr[1], wr_data[1]);
            end
        end
        if (init_pc !== 32'h0000_0040) begin fails++; $display("FAIL %s_init_pc: got %h want 00000040", name, init_pc); end
        if (cpu_run !== 1'b1 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL %s_final: cpu_run=%b load_err=%b want 1 0", name, cpu_run, load_err);
        end
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_run: got %b want 0", name, bus.in_ready); end
`ifdef LOADER_CHECKSUM_EN
        exp_run = last_acc;
`else
        exp_run = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] + 1 : -2;
`endif
        if (run_cyc != exp_run) begin fails++; $display("FAIL %s_run_time: got cyc %0d want %0d", name, run_cyc, exp_run); end
        if (gap == 0) begin
            // Write strobe exactly one cycle after the last payload byte.
            tests++;
`ifdef LOADER_CHECKSUM_EN
            exp_run = last_acc - 1;
`else
            exp_run = last_acc;
`endif
            if (wr_cyc.size() != 2 || wr_cyc[1] != exp_run) begin
                fails++;
                $display("FAIL %s_we_latency: last write cyc %0d want %0d", name,
                         (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -1, exp_run);
            end
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        stream.delete();
        put32(32'h0000_0000);
        put16(16'd0);
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(stream_xor());
`endif
        send_stream(0, 1'b0);
        wait_done(20);
        tests += 4;
        if (wr_addr.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        if (cpu_run !== 1'b1 || load_err !== 1'b0) begin fails++; $display("FAIL zero_final: cpu_run=%b load_err=%b want 1 0", cpu_run, load_err); end
        if (run_cyc != last_acc) begin fails++; $display("FAIL zero_run_time: got cyc %0d want %0d", run_cyc, last_acc); end
        if (init_pc !== 32'h0) begin fails++; $display("FAIL zero_init_pc: got %h want 0", init_pc); end
    endtask

    task automatic test_overflow();
        do_reset();
        stream.delete();
        put32(32'h1234_5678);
        put16(16'h0101);
        send_stream(0, 1'b0);
        tests += 3;
        if (load_err !== 1'b1) begin fails++; $display("FAIL ovf_load_err: got %b want 1", load_err); end
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready: got %b want 0", bus.in_ready); end
        if (cpu_run !== 1'b0) begin fails++; $display("FAIL ovf_cpu_run: got %b want 0", cpu_run); end
        // Keep offering bytes: the error state must not move.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (8) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tests += 3;
        if (load_err !== 1'b1 || cpu_run !== 1'b0) begin fails++; $display("FAIL ovf_terminal: load_err=%b cpu_run=%b want 1 0", load_err, cpu_run); end
        if (wr_addr.size() != 0) begin fails++; $display("FAIL ovf_writes: got %0d want 0", wr_addr.size()); end
        if (init_pc !== 32'h1234_5678) begin fails++; $display("FAIL ovf_init_pc: got %h want 12345678", init_pc); end
    endtask

    task automatic test_boundary_count();
        // cnt = 2^ADDR_W is the largest legal count: must enter LOAD, not ERR.
        do_reset();
        stream.delete();
        put32(32'h0000_0100);
        put16(16'h0100);
        send_stream(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests += 2;
        if (load_err !== 1'b0) begin fails++; $display("FAIL cap_load_err: got %b want 0", load_err); end
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL cap_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        stream.delete();
        put32(32'h0000_0080);
        put16(16'd1);
        stream.push_back(8'h11);
        stream.push_back(8'h22);
        send_stream(0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests += 5;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
        if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL mid_imem_we: got %b want 0", bus.imem_we); end
        if (init_pc !== 32'h0) begin fails++; $display("FAIL mid_init_pc: got %h want 0", init_pc); end
        if (cpu_run !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL mid_flags: cpu_run=%b load_err=%b want 0 0", cpu_run, load_err); end
        if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_imem_bus: addr %h data %h want 00 0", bus.imem_addr, bus.imem_wdata);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        run_cyc = -1;
        stream.delete();
        put32(32'h0000_0010);
        put16(16'd1);
        put32(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(stream_xor());
`endif
        send_stream(0, 1'b0);
        wait_done(20);
        tests += 3;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL mid_reload_write: count %0d want 1 write of DEADBEEF at 0", wr_addr.size());
        end
        if (cpu_run !== 1'b1) begin fails++; $display("FAIL mid_reload_run: got %b want 1", cpu_run); end
        if (init_pc !== 32'h0000_0010) begin fails++; $display("FAIL mid_reload_pc: got %h want 00000010", init_pc); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        do_reset();
        stream.delete();
        put32(32'h0000_0040);
        put16(16'd2);
        put32(32'h2001_0005);
        put32(32'h0021_1020);
        tests++;
        if (stream_xor() !== 8'h77) begin fails++; $display("FAIL chk_model: got %h want 77", stream_xor()); end
        stream.push_back(8'h77 ^ 8'h01);
        send_stream(0, 1'b0);
        wait_done(30);
        tests += 3;
        if (load_err !== 1'b1) begin fails++; $display("FAIL chk_bad_err: got %b want 1", load_err); end
        if (cpu_run !== 1'b0) begin fails++; $display("FAIL chk_bad_run: got %b want 0", cpu_run); end
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL chk_bad_ready: got %b want 0", bus.in_ready); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_load(0, "basic");
        test_load(3, "stalled");
        test_zero_count();
        test_overflow();
        test_boundary_count();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
